// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through L1 data cache and its memory-side bridge.
// Holds the request/return payload structs, the bridge state encoding and
// the bridge sizing defaults.
package wt_cache_pkg;

  // Request from the dcache towards memory
  typedef struct packed {
    logic [1:0]  rtype;
    logic [2:0]  size;
    logic [1:0]  tid;
    logic        nc;
    logic [31:0] paddr;
    logic [31:0] data;
  } dcache_req_t;

  // Return from memory towards the dcache
  typedef struct packed {
    logic [1:0]  rtype;
    logic [1:0]  tid;
    logic [31:0] data;
  } dcache_rtrn_t;

  // Flush drain state of the bridge
  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } bridge_state_e;

  localparam int BRIDGE_FIFO_DEPTH_DEFAULT      = 4;
  localparam int BRIDGE_MAX_OUTSTANDING_DEFAULT = 8;

  // 32-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/wt_dcache_req_fifo.sv
// Request FIFO between the dcache and the downstream adapter.
// Power-of-two depth, pointers wrap naturally, occupancy count exported.
// The head of an empty FIFO reads as all zeros.
module wt_dcache_req_fifo
  import wt_cache_pkg::*;
#(
  parameter int Depth = BRIDGE_FIFO_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  dcache_req_t           wdata,
  output dcache_req_t           rdata,
  output logic [$clog2(Depth):0] fcnt
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

  dcache_req_t       storage [Depth];
  logic [PtrW-1:0]   wptr;
  logic [PtrW-1:0]   rptr;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && (fcnt != FullCnt);
  assign pop_ok  = pop && (fcnt != '0);

  // Pointers and occupancy; a push and pop together leave the count alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + PtrW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + PtrW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   fcnt <= fcnt + (PtrW+1)'(1);
        2'b01:   fcnt <= fcnt - (PtrW+1)'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

  // Payload storage; contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      storage[wptr] <= wdata;
    end
  end

  assign rdata = (fcnt == '0) ? '0 : storage[rptr];

endmodule

// File: rtl/wt_dcache_mem_bridge.sv
// Decoupling bridge between the write-through dcache and the L1.5/NoC
// adapter: buffers requests, limits in-flight transactions with a credit
// counter, registers returns and implements the flush drain handshake.
// Optional perf counters are built when WT_DCACHE_BRIDGE_PERF_EN is defined;
// otherwise req_cnt_o and stall_cnt_o read zero.
module wt_dcache_mem_bridge
  import wt_cache_pkg::*;
#(
  parameter int FifoDepth      = BRIDGE_FIFO_DEPTH_DEFAULT,
  parameter int MaxOutstanding = BRIDGE_MAX_OUTSTANDING_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mem_data_req_i,
  output logic                      mem_data_ack_o,
  input  logic [$bits(dcache_req_t)-1:0]  mem_data_i,
  output logic                      mem_rtrn_vld_o,
  output logic [$bits(dcache_rtrn_t)-1:0] mem_rtrn_o,
  output logic                      req_valid_o,
  input  logic                      req_ready_i,
  output logic [$bits(dcache_req_t)-1:0]  req_o,
  input  logic                      rtrn_vld_i,
  input  logic [$bits(dcache_rtrn_t)-1:0] rtrn_i,
  input  logic                      flush_i,
  output logic                      drained_o,
  output logic                      err_o,
  output logic [31:0]               req_cnt_o,
  output logic [31:0]               stall_cnt_o
);

  localparam int FCntW = $clog2(FifoDepth) + 1;
  localparam int OCntW = $clog2(MaxOutstanding) + 1;
  localparam logic [FCntW-1:0] FifoFull = FCntW'(FifoDepth);
  localparam logic [OCntW-1:0] OcntMax  = OCntW'(MaxOutstanding);

  bridge_state_e     state;
  bridge_state_e     state_next;
  logic              drained_next;
  logic [FCntW-1:0]  fcnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [OCntW-1:0]  ocnt;
  logic              issue;
  logic              err;
  dcache_req_t       head;

  assign fifo_full  = (fcnt == FifoFull);
  assign fifo_empty = (fcnt == '0);

  // Accept only while running and not full on the registered count; the
  // reset term keeps the ack low while reset is held
  assign mem_data_ack_o = mem_data_req_i && !fifo_full && (state == RUN) && !rst_i;
  assign req_valid_o    = !fifo_empty && (ocnt < OcntMax);
  assign issue          = req_valid_o && req_ready_i;
  assign req_o          = head;
  assign err_o          = err;

  wt_dcache_req_fifo #(
    .Depth (FifoDepth)
  ) u_req_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (mem_data_ack_o),
    .pop   (issue),
    .wdata (dcache_req_t'(mem_data_i)),
    .rdata (head),
    .fcnt  (fcnt)
  );

  // Credit counter: issue adds, return removes, both together cancel; a
  // return with nothing outstanding flags the sticky error and never wraps
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ocnt <= '0;
      err  <= 1'b0;
    end else begin
      if (rtrn_vld_i && (ocnt == '0)) begin
        err <= 1'b1;
      end
      if (issue && !rtrn_vld_i) begin
        ocnt <= ocnt + OCntW'(1);
      end else if (!issue && rtrn_vld_i && (ocnt != '0)) begin
        ocnt <= ocnt - OCntW'(1);
      end
    end
  end

  // Return register: valid follows the adapter one cycle later, payload is
  // captured only on a valid return
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_rtrn_vld_o <= 1'b0;
      mem_rtrn_o     <= '0;
    end else begin
      mem_rtrn_vld_o <= rtrn_vld_i;
      if (rtrn_vld_i) begin
        mem_rtrn_o <= rtrn_i;
      end
    end
  end

  // Drain FSM next state; the drained pulse fires only on DRAIN -> DONE
  always_comb begin
    state_next   = state;
    drained_next = 1'b0;
    case (state)
      RUN: begin
        if (flush_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!flush_i) begin
          state_next = RUN;
        end else if (fifo_empty && (ocnt == '0)) begin
          state_next   = DONE;
          drained_next = 1'b1;
        end
      end
      DONE: begin
        if (!flush_i) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Drain FSM state register and registered drained pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= RUN;
      drained_o <= 1'b0;
    end else begin
      state     <= state_next;
      drained_o <= drained_next;
    end
  end

`ifdef WT_DCACHE_BRIDGE_PERF_EN
  logic [31:0] req_cnt;
  logic [31:0] stall_cnt;

  // Saturating counts of issued requests and adapter backpressure cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (issue) begin
        req_cnt <= sat_inc32(req_cnt);
      end
      if (req_valid_o && !req_ready_i) begin
        stall_cnt <= sat_inc32(stall_cnt);
      end
    end
  end

  assign req_cnt_o   = req_cnt;
  assign stall_cnt_o = stall_cnt;
`else
  assign req_cnt_o   = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wt_dcache_mem_bridge.sv
// Self-checking bench for wt_dcache_mem_bridge: a vector table for the basic
// flow, hand-written sequences for backpressure, credit limit, flush drain,
// perf counters and mid-burst reset, then randomized traffic against a
// queue-based reference model. Perf expectations follow
// WT_DCACHE_BRIDGE_PERF_EN.
module tb_wt_dcache_mem_bridge;
  import wt_cache_pkg::*;

  localparam int FD = 4;
  localparam int MO = 8;
  localparam int MS_RUN   = 0;
  localparam int MS_DRAIN = 1;
  localparam int MS_DONE  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_data_req = 1'b0;
  logic         mem_data_ack;
  dcache_req_t  mem_data = '0;
  logic         mem_rtrn_vld;
  dcache_rtrn_t mem_rtrn;
  logic         req_valid;
  logic         req_ready = 1'b0;
  dcache_req_t  req;
  logic         rtrn_vld = 1'b0;
  dcache_rtrn_t rtrn = '0;
  logic         flush = 1'b0;
  logic         drained;
  logic         err;
  logic [31:0]  req_cnt;
  logic [31:0]  stall_cnt;

  always #5 clk = ~clk;

  wt_dcache_mem_bridge #(
    .FifoDepth      (FD),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_data_req_i (mem_data_req),
    .mem_data_ack_o (mem_data_ack),
    .mem_data_i     (mem_data),
    .mem_rtrn_vld_o (mem_rtrn_vld),
    .mem_rtrn_o     (mem_rtrn),
    .req_valid_o    (req_valid),
    .req_ready_i    (req_ready),
    .req_o          (req),
    .rtrn_vld_i     (rtrn_vld),
    .rtrn_i         (rtrn),
    .flush_i        (flush),
    .drained_o      (drained),
    .err_o          (err),
    .req_cnt_o      (req_cnt),
    .stall_cnt_o    (stall_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int acks_seen, issues_seen, drains_seen;

  // Reference model state
  dcache_req_t  mq[$];
  dcache_req_t  src[$];
  int           mocnt, mst;
  bit           mdrained, merr, mrvld;
  dcache_rtrn_t mrtrn;
  int unsigned  mreq_cnt, mstall;

  typedef struct {
    bit          req;
    bit          ready;
    bit          rtrn;
    bit          flush;
    logic [31:0] tag;
    bit          e_ack;
    bit          e_valid;
    logic [31:0] e_tag;
    bit          e_rvld;
    bit          e_drained;
    bit          e_err;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  task automatic check_value(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_perf(input int unsigned v);
`ifdef WT_DCACHE_BRIDGE_PERF_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic dcache_req_t mk_req(input logic [31:0] tag);
    dcache_req_t r;
    r = '0;
    r.paddr = tag;
    r.data  = ~tag;
    return r;
  endfunction

  function automatic dcache_req_t rand_req();
    dcache_req_t r;
    r.rtype = 2'($urandom());
    r.size  = 3'($urandom());
    r.tid   = 2'($urandom());
    r.nc    = 1'($urandom());
    r.paddr = $urandom();
    r.data  = $urandom();
    return r;
  endfunction

  function automatic dcache_rtrn_t rand_rtrn();
    dcache_rtrn_t r;
    r.rtype = 2'($urandom());
    r.tid   = 2'($urandom());
    r.data  = $urandom();
    return r;
  endfunction

  function automatic vec_t mkv(bit rq, bit rd, bit rt, bit fl, logic [31:0] tg,
                               bit ea, bit ev, logic [31:0] et, bit er, bit ed, bit ee);
    vec_t v;
    v.req = rq; v.ready = rd; v.rtrn = rt; v.flush = fl; v.tag = tg;
    v.e_ack = ea; v.e_valid = ev; v.e_tag = et; v.e_rvld = er; v.e_drained = ed; v.e_err = ee;
    return v;
  endfunction

  function automatic void model_reset();
    mq.delete();
    src.delete();
    mocnt = 0; mst = MS_RUN;
    mdrained = 0; merr = 0; mrvld = 0; mrtrn = '0;
    mreq_cnt = 0; mstall = 0;
  endfunction

  function automatic bit m_ack();
    return mem_data_req && (mq.size() < FD) && (mst == MS_RUN);
  endfunction

  function automatic bit m_valid();
    return (mq.size() != 0) && (mocnt < MO);
  endfunction

  function automatic dcache_req_t m_head();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  // Advance the model by one clock using the inputs present at the edge
  function automatic void model_update();
    bit a, v, iss, nd;
    int ns;
    a = m_ack(); v = m_valid(); iss = v && req_ready; nd = 0; ns = mst;
    if (mst == MS_RUN && flush) ns = MS_DRAIN;
    else if (mst == MS_DRAIN) begin
      if (!flush) ns = MS_RUN;
      else if (mq.size() == 0 && mocnt == 0) begin ns = MS_DONE; nd = 1; end
    end else if (mst == MS_DONE && !flush) ns = MS_RUN;
    if (iss) begin void'(mq.pop_front()); mreq_cnt++; end
    if (v && !req_ready) mstall++;
    if (a) begin mq.push_back(mem_data); void'(src.pop_front()); end
    if (rtrn_vld && mocnt == 0) merr = 1;
    if (iss && !rtrn_vld) mocnt++;
    else if (!iss && rtrn_vld && mocnt > 0) mocnt--;
    mrvld = rtrn_vld;
    if (rtrn_vld) mrtrn = rtrn;
    mst = ns;
    mdrained = nd;
  endfunction

  task automatic checkOutput();
    acks_seen   += int'(mem_data_ack);
    issues_seen += int'(req_valid && req_ready);
    drains_seen += int'(drained);
    check_value("ack", mem_data_ack, m_ack());
    check_value("req_valid", req_valid, m_valid());
    check_value("req_o", req, m_head());
    check_value("rtrn_vld", mem_rtrn_vld, mrvld);
    check_value("rtrn_o", mem_rtrn, mrtrn);
    check_value("drained", drained, mdrained);
    check_value("err", err, merr);
    check_value("req_cnt", req_cnt, exp_perf(mreq_cnt));
    check_value("stall_cnt", stall_cnt, exp_perf(mstall));
  endtask

  // Drive one cycle: offer the head of the source queue, check at the
  // falling edge, advance the model on the rising edge
  task automatic applyStimulus(input bit rdy, input bit rt, input bit fl);
    if (src.size() != 0) begin mem_data_req = 1'b1; mem_data = src[0]; end
    else begin mem_data_req = 1'b0; mem_data = '0; end
    req_ready = rdy;
    rtrn_vld  = rt;
    rtrn      = rand_rtrn();
    flush     = fl;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_data_req = 0; mem_data = '0; req_ready = 0; rtrn_vld = 0; rtrn = '0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_value("rst_valid", req_valid, 1'b0);
    check_value("rst_req_o", req, 72'd0);
    check_value("rst_rtrn_vld", mem_rtrn_vld, 1'b0);
    check_value("rst_rtrn_o", mem_rtrn, 36'd0);
    check_value("rst_drained", drained, 1'b0);
    check_value("rst_err", err, 1'b0);
    check_value("rst_req_cnt", req_cnt, 32'd0);
    check_value("rst_stall_cnt", stall_cnt, 32'd0);
  endtask

  initial begin
    dcache_rtrn_t rt_fix;
    dcache_req_t  first;
    bit           fl_r;

    rt_fix = '0;
    rt_fix.data = 32'hCAFE_0001;
    // req ready rtrn flush tag | ack valid etag rvld drained err
    tbl[0]  = mkv(1, 1, 0, 0, 32'hA1, 1, 0, 0,     0, 0, 0);
    tbl[1]  = mkv(0, 1, 0, 0, 0,      0, 1, 32'hA1, 0, 0, 0);
    tbl[2]  = mkv(0, 1, 0, 0, 0,      0, 0, 0,     0, 0, 0);
    tbl[3]  = mkv(0, 1, 1, 0, 0,      0, 0, 0,     0, 0, 0);
    tbl[4]  = mkv(0, 1, 0, 0, 0,      0, 0, 0,     1, 0, 0);
    tbl[5]  = mkv(0, 1, 1, 0, 0,      0, 0, 0,     0, 0, 0);
    tbl[6]  = mkv(0, 1, 0, 0, 0,      0, 0, 0,     1, 0, 1);
    tbl[7]  = mkv(0, 1, 0, 0, 0,      0, 0, 0,     0, 0, 1);
    tbl[8]  = mkv(0, 1, 0, 1, 0,      0, 0, 0,     0, 0, 1);
    tbl[9]  = mkv(0, 1, 0, 1, 0,      0, 0, 0,     0, 0, 1);
    tbl[10] = mkv(0, 1, 0, 1, 0,      0, 0, 0,     0, 1, 1);
    tbl[11] = mkv(1, 1, 0, 1, 32'hB2, 0, 0, 0,     0, 0, 1);
    tbl[12] = mkv(1, 1, 0, 0, 32'hB2, 0, 0, 0,     0, 0, 1);
    tbl[13] = mkv(1, 1, 0, 0, 32'hB2, 1, 0, 0,     0, 0, 1);
    tbl[14] = mkv(0, 1, 0, 0, 0,      0, 1, 32'hB2, 0, 0, 1);
    tbl[15] = mkv(0, 1, 1, 0, 0,      0, 0, 0,     0, 0, 1);
    tbl[16] = mkv(0, 1, 0, 0, 0,      0, 0, 0,     1, 0, 1);

    $display("[TB] vector table");
    do_reset();
    for (int i = 0; i < NV; i++) begin
      mem_data_req = tbl[i].req;
      mem_data     = mk_req(tbl[i].tag);
      req_ready    = tbl[i].ready;
      rtrn_vld     = tbl[i].rtrn;
      rtrn         = rt_fix;
      flush        = tbl[i].flush;
      @(negedge clk);
      check_value($sformatf("vec%0d_ack", i), mem_data_ack, tbl[i].e_ack);
      check_value($sformatf("vec%0d_valid", i), req_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) check_value($sformatf("vec%0d_req_o", i), req, mk_req(tbl[i].e_tag));
      check_value($sformatf("vec%0d_rvld", i), mem_rtrn_vld, tbl[i].e_rvld);
      if (tbl[i].e_rvld) check_value($sformatf("vec%0d_rtrn_o", i), mem_rtrn, rt_fix);
      check_value($sformatf("vec%0d_drained", i), drained, tbl[i].e_drained);
      check_value($sformatf("vec%0d_err", i), err, tbl[i].e_err);
      @(posedge clk);
      #1;
    end

    $display("[TB] backpressure");
    do_reset();
    for (int i = 0; i < 5; i++) src.push_back(rand_req());
    first = src[0];
    acks_seen = 0;
    repeat (8) applyStimulus(0, 0, 0);
    check_value("bp_acks", 128'(acks_seen), 128'd4);
    check_value("bp_head_stable", req, first);
    acks_seen = 0;
    applyStimulus(1, 0, 0);
    check_value("bp_no_ack_on_pop", 128'(acks_seen), 128'd0);
    applyStimulus(1, 0, 0);
    check_value("bp_ack_after_pop", 128'(acks_seen), 128'd1);
    repeat (12) applyStimulus(1, mocnt > 0, 0);

    $display("[TB] credit limit");
    do_reset();
    for (int i = 0; i < 12; i++) src.push_back(rand_req());
    issues_seen = 0;
    repeat (16) applyStimulus(1, 0, 0);
    check_value("cr_issues", 128'(issues_seen), 128'd8);
    check_value("cr_valid_low", req_valid, 1'b0);
    check_value("cr_fifo_nonempty", dut.fcnt != 0, 1'b1);
    applyStimulus(1, 1, 0);
    issues_seen = 0;
    applyStimulus(1, 1, 0);
    check_value("cr_issue_after_rtrn", 128'(issues_seen), 128'd1);
    check_value("cr_ocnt_same", 128'(dut.ocnt), 128'd7);
    applyStimulus(1, 0, 0);
    check_value("cr_ocnt_full", 128'(dut.ocnt), 128'd8);
    repeat (30) applyStimulus(1, mocnt > 0, 0);

    $display("[TB] flush drain");
    do_reset();
    for (int i = 0; i < 3; i++) src.push_back(rand_req());
    repeat (5) applyStimulus(1, 0, 0);
    for (int i = 0; i < 2; i++) src.push_back(rand_req());
    repeat (3) applyStimulus(0, 0, 0);
    check_value("fl_outstanding", 128'(dut.ocnt), 128'd3);
    check_value("fl_fifo", 128'(dut.fcnt), 128'd2);
    drains_seen = 0;
    applyStimulus(0, 0, 1);
    src.push_back(rand_req());
    acks_seen = 0;
    repeat (20) applyStimulus(1, mocnt > 0, 1);
    check_value("fl_ack_blocked", 128'(acks_seen), 128'd0);
    check_value("fl_one_pulse", 128'(drains_seen), 128'd1);
    acks_seen = 0;
    repeat (2) applyStimulus(1, 0, 0);
    check_value("fl_resume", 128'(acks_seen), 128'd1);
    repeat (6) applyStimulus(1, mocnt > 0, 0);

    $display("[TB] perf counters");
    do_reset();
    src.push_back(rand_req());
    repeat (4) applyStimulus(0, 0, 0);
    for (int i = 0; i < 9; i++) src.push_back(rand_req());
    repeat (14) applyStimulus(1, mocnt > 0, 0);
    check_value("perf_req_cnt", req_cnt, exp_perf(10));
    check_value("perf_stall_cnt", stall_cnt, exp_perf(3));

    $display("[TB] reset mid-burst");
    do_reset();
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 6; i++) src.push_back(rand_req());
    repeat (3) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    check_value("mr_err_before", err, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_value("mr_ack", mem_data_ack, 1'b0);
    check_value("mr_valid", req_valid, 1'b0);
    check_value("mr_req_o", req, 72'd0);
    check_value("mr_rtrn_vld", mem_rtrn_vld, 1'b0);
    check_value("mr_rtrn_o", mem_rtrn, 36'd0);
    check_value("mr_err", err, 1'b0);
    check_value("mr_drained", drained, 1'b0);
    check_value("mr_req_cnt", req_cnt, 32'd0);
    do_reset();

    $display("[TB] random traffic");
    fl_r = 0;
    for (int c = 0; c < 3000; c++) begin
      bit rt;
      if (src.size() == 0 && $urandom_range(1, 0) == 1) src.push_back(rand_req());
      if (!fl_r) fl_r = ($urandom_range(59, 0) == 0);
      else if (mst == MS_DONE) fl_r = ($urandom_range(3, 0) != 0);
      else fl_r = ($urandom_range(39, 0) != 0);
      rt = (mocnt > 0) ? ($urandom_range(2, 0) == 0) : ($urandom_range(199, 0) == 0);
      applyStimulus($urandom_range(3, 0) != 0, rt, fl_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
